// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b, one bit per clock, LSB first.
// A single borrow flip-flop carries between bit positions. The partial
// result shifts in from the MSB side in a private register, and the
// visible outputs are written only once, when the last bit is done.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bo,
  output logic             ovf,
  output logic             zero
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Index of the last bit position; 6 bits covers the full 1..32 range.
  localparam logic [5:0] LAST = 6'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [WIDTH-1:0] res_next;
  logic             br;
  logic             br_next;
  logic             bit_d;
  logic             a_msb;
  logic             b_msb;
  logic [5:0]       count;

  // One full-subtractor slice on the current LSBs, plus the shifted result.
  always_comb begin
    bit_d    = a_sh[0] ^ b_sh[0] ^ br;
    br_next  = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
    res_next = (res_sh >> 1) | (WIDTH'(bit_d) << (WIDTH - 1));
  end

  // Control FSM, operand/result shifters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      br     <= 1'b0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      count  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      bo     <= 1'b0;
      ovf    <= 1'b0;
      zero   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_sh   <= a;
            b_sh   <= b;
            a_msb  <= a[WIDTH-1];
            b_msb  <= b[WIDTH-1];
            res_sh <= '0;
            br     <= 1'b0;
            count  <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end else begin
            state  <= IDLE;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          br     <= br_next;
          res_sh <= res_next;
          count  <= count + 6'd1;
          if (count == LAST) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            diff  <= res_next;
            bo    <= br_next;
            ovf   <= (a_msb != b_msb) && (res_next[WIDTH-1] != a_msb);
            zero  <= (res_next == '0);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: WIDTH=8 and WIDTH=1 instances,
// directed vector table, multi-cycle corner sequences and a random run.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] diff;
  logic       bo;
  logic       ovf;
  logic       zero;

  logic       start1;
  logic       a1;
  logic       b1;
  logic       busy1;
  logic       done1;
  logic       diff1;
  logic       bo1;
  logic       ovf1;
  logic       zero1;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] diff;
    logic       bo;
    logic       ovf;
    logic       zero;
  } vec_t;

  vec_t vecs[9];

  serial_subtractor #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .bo(bo), .ovf(ovf), .zero(zero)
  );

  serial_subtractor #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .diff(diff1), .bo(bo1), .ovf(ovf1), .zero(zero1)
  );

  always #5 clk = ~clk;

  // Compare one value and report a mismatch.
  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Called at a negedge: pulse start for one cycle, then wait for done.
  // cycles counts negedges from the start cycle to the done cycle inclusive.
  task automatic apply_stimulus(input logic [7:0] ai, input logic [7:0] bi,
                                output int cycles, output int busy_cnt);
    a = ai;
    b = bi;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cycles = 1;
    busy_cnt = 0;
    while (!done && cycles < 40) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      cycles++;
    end
    if (!done) begin
      checks++;
      fails++;
      $display("[TB] FAIL done_timeout: got no done, expected done within 40 cycles");
    end
  endtask

  // Same handshake for the WIDTH=1 instance.
  task automatic apply_stimulus1(input logic ai, input logic bi, output int cycles);
    a1 = ai;
    b1 = bi;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    cycles = 1;
    while (!done1 && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  initial begin
    int cyc;
    int bcnt;
    int ndone;
    logic [7:0] got;
    logic [7:0] ra;
    logic [7:0] rb;
    logic [7:0] rd;
    logic [1:0] ab;

    vecs[0] = '{8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{8'hA5, 8'hA5, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{8'h00, 8'hFF, 8'h01, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{8'hFF, 8'h01, 8'hFE, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, 1'b0};
    vecs[8] = '{8'h80, 8'h7F, 8'h01, 1'b0, 1'b1, 1'b0};

    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    start1 = 1'b0; a1 = 1'b0; b1 = 1'b0;
    repeat (3) @(negedge clk);
    check_output("reset_busy", int'(busy), 0);
    check_output("reset_done", int'(done), 0);
    check_output("reset_diff", int'(diff), 0);
    check_output("reset_flags", int'({bo, ovf, zero}), 0);
    check_output("reset_w1", int'({busy1, done1, diff1, bo1, ovf1, zero1}), 0);
    rst = 1'b0;
    @(negedge clk);

    // Directed vector table.
    for (int i = 0; i < 9; i++) begin
      apply_stimulus(vecs[i].a, vecs[i].b, cyc, bcnt);
      check_output($sformatf("v%0d_latency", i), cyc, 9);
      check_output($sformatf("v%0d_busy_cycles", i), bcnt, 8);
      check_output($sformatf("v%0d_busy_in_done", i), int'(busy), 0);
      check_output($sformatf("v%0d_diff", i), int'(diff), int'(vecs[i].diff));
      check_output($sformatf("v%0d_bo", i), int'(bo), int'(vecs[i].bo));
      check_output($sformatf("v%0d_ovf", i), int'(ovf), int'(vecs[i].ovf));
      check_output($sformatf("v%0d_zero", i), int'(zero), int'(vecs[i].zero));
      @(negedge clk);
      check_output($sformatf("v%0d_done_pulse", i), int'(done), 0);
      check_output($sformatf("v%0d_diff_hold", i), int'(diff), int'(vecs[i].diff));
    end

    // Re-pulsed start with new operands while busy is ignored.
    a = 8'd9; b = 8'd4; start = 1'b1;
    ndone = 0; got = '0;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      start = (k == 4);
      if (k == 4) begin a = 8'd1; b = 8'd2; end
      if (done) begin ndone++; got = diff; end
    end
    start = 1'b0;
    check_output("ignore_start_dones", ndone, 1);
    check_output("ignore_start_diff", int'(got), 5);

    // Start during the DONE cycle is accepted back to back.
    @(negedge clk);
    apply_stimulus(8'h40, 8'h10, cyc, bcnt);
    check_output("b2b_first_diff", int'(diff), 8'h30);
    apply_stimulus(8'h10, 8'h40, cyc, bcnt);
    check_output("b2b_second_latency", cyc, 9);
    check_output("b2b_second_diff", int'(diff), 8'hD0);
    check_output("b2b_second_bo", int'(bo), 1);

    // Reset in the middle of RUN aborts with no done pulse.
    @(negedge clk);
    a = 8'h33; b = 8'h11; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_output("abort_busy", int'(busy), 0);
    check_output("abort_done", int'(done), 0);
    check_output("abort_diff", int'(diff), 0);
    check_output("abort_flags", int'({bo, ovf, zero}), 0);
    ndone = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check_output("abort_no_done", ndone, 0);
    apply_stimulus(8'h33, 8'h11, cyc, bcnt);
    check_output("after_abort_diff", int'(diff), 8'h22);
    check_output("after_abort_latency", cyc, 9);

    // WIDTH=1 truth table: {a,b} -> diff, bo, ovf.
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      ab = 2'(k);
      apply_stimulus1(ab[1], ab[0], cyc);
      check_output($sformatf("w1_%0d_latency", k), cyc, 2);
      check_output($sformatf("w1_%0d_diff", k), int'(diff1), int'(ab[1] ^ ab[0]));
      check_output($sformatf("w1_%0d_bo", k), int'(bo1), int'(~ab[1] & ab[0]));
      check_output($sformatf("w1_%0d_ovf", k), int'(ovf1), int'(~ab[1] & ab[0]));
      check_output($sformatf("w1_%0d_zero", k), int'(zero1), int'(ab[1] == ab[0]));
      @(negedge clk);
    end

    // Random regression against behavioural subtraction.
    for (int n = 0; n < 1000; n++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rd = ra - rb;
      apply_stimulus(ra, rb, cyc, bcnt);
      check_output($sformatf("rnd%0d_diff", n), int'(diff), int'(rd));
      check_output($sformatf("rnd%0d_bo", n), int'(bo), int'(ra < rb));
      check_output($sformatf("rnd%0d_ovf", n), int'(ovf),
                   int'((ra[7] != rb[7]) && (rd[7] != ra[7])));
      check_output($sformatf("rnd%0d_zero", n), int'(zero), int'(rd == 8'h00));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
